// File: rtl/csa_reduce_pipe_if.sv
// csa_reduce_pipe_if: operand-beat input and sum/carry result output handshakes.
// The master drives beats and consumes results; the slave is the reduction tree.
interface csa_reduce_pipe_if #(
  parameter int WIDTH  = 10,
  parameter int NUM_IN = 9,
  parameter int TAG_W  = 4
);
  logic                    io_in_valid;
  logic                    io_in_ready;
  logic [NUM_IN*WIDTH-1:0] io_in_data;
  logic [TAG_W-1:0]        io_in_tag;
  logic                    io_out_valid;
  logic                    io_out_ready;
  logic [WIDTH-1:0]        io_out_sum;
  logic [WIDTH-1:0]        io_out_carry;
  logic [TAG_W-1:0]        io_out_tag;

  modport master (
    output io_in_valid,
    output io_in_data,
    output io_in_tag,
    output io_out_ready,
    input  io_in_ready,
    input  io_out_valid,
    input  io_out_sum,
    input  io_out_carry,
    input  io_out_tag
  );

  modport slave (
    input  io_in_valid,
    input  io_in_data,
    input  io_in_tag,
    input  io_out_ready,
    output io_in_ready,
    output io_out_valid,
    output io_out_sum,
    output io_out_carry,
    output io_out_tag
  );
endinterface

// File: rtl/csa_reduce_pipe.sv
// csa_reduce_pipe: pipelined 3:2 carry-save reduction tree, one register per layer.
// Define CSA_FINAL_ADD_EN to append a registered carry-propagate stage.
module csa_reduce_pipe #(
  parameter int WIDTH  = 10,
  parameter int NUM_IN = 9,
  parameter int TAG_W  = 4
) (
  input  logic             clock,
  input  logic             reset,
  csa_reduce_pipe_if.slave io
);

  localparam int LEVELS = (NUM_IN == 3) ? 1 :
                          (NUM_IN == 4) ? 2 :
                          (NUM_IN == 6) ? 3 : 4;
`ifdef CSA_FINAL_ADD_EN
  localparam int FA = 1;
`else
  localparam int FA = 0;
`endif
  localparam int NST = LEVELS + FA;

  if (NUM_IN != 3 && NUM_IN != 4 &&
      NUM_IN != 6 && NUM_IN != 9) begin : g_bad_num_in
    $error("csa_reduce_pipe: NUM_IN must be 3, 4, 6 or 9");
  end

  // rows present after layer s; s = 0 is the raw operand set
  function automatic int rows_at(int s);
    int r;
    case (LEVELS - s)
      4:       r = 9;
      3:       r = 6;
      2:       r = 4;
      1:       r = 3;
      default: r = 2;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] lin [LEVELS][NUM_IN];
  logic [WIDTH-1:0] nxt [LEVELS][NUM_IN];
  logic [WIDTH-1:0] q   [LEVELS][NUM_IN];
  logic [TAG_W-1:0] tg  [NST];
  logic [NST-1:0]   v;
  logic [NST-1:0]   ld;
  logic [NST:0]     take;

  // take[i]: stage i loads this edge; chained straight from io_out_ready
  always_comb begin
    take = '0;
    ld   = '0;
    take[NST] = io.io_out_ready;
    for (int i = NST - 1; i >= 0; i--) begin
      take[i] = !v[i] || take[i + 1];
    end
    ld[0] = take[0] && io.io_in_valid;
    for (int i = 1; i < NST; i++) begin
      ld[i] = take[i] && v[i - 1];
    end
  end

  always_comb begin
    logic [WIDTH-1:0] a, b, c, cy;
    int r, g, l, k, m;
    a  = '0;
    b  = '0;
    c  = '0;
    cy = '0;
    r  = 0;
    g  = 0;
    l  = 0;
    k  = 0;
    m  = 0;
    for (int j = 0; j < NUM_IN; j++) begin
      lin[0][j] = io.io_in_data[j*WIDTH +: WIDTH];
    end
    for (int i = 1; i < LEVELS; i++) begin
      for (int j = 0; j < NUM_IN; j++) begin
        lin[i][j] = q[i - 1][j];
      end
    end
    for (int i = 0; i < LEVELS; i++) begin
      for (int j = 0; j < NUM_IN; j++) begin
        nxt[i][j] = '0;
      end
      r = rows_at(i);
      g = r / 3;
      l = r % 3;
      for (int p = 0; p < NUM_IN / 3; p++) begin
        if (p < g) begin
          a  = lin[i][3*p];
          b  = lin[i][3*p + 1];
          c  = lin[i][3*p + 2];
          cy = (a & b) | ((a ^ b) & c);
          nxt[i][2*p]     = a ^ b ^ c;
          nxt[i][2*p + 1] = {cy[WIDTH-2:0], 1'b0};
        end
      end
      // leftover rows ride along untouched, after all group outputs
      for (int j = 0; j < 2; j++) begin
        k = 2*g + j;
        m = 3*g + j;
        if (j < l && k < NUM_IN && m < NUM_IN) begin
          nxt[i][k] = lin[i][m];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      v <= '0;
      for (int i = 0; i < NST; i++) begin
        tg[i] <= '0;
      end
      for (int i = 0; i < LEVELS; i++) begin
        for (int j = 0; j < NUM_IN; j++) begin
          q[i][j] <= '0;
        end
      end
    end else begin
      if (take[0]) v[0] <= io.io_in_valid;
      if (ld[0])   tg[0] <= io.io_in_tag;
      for (int i = 1; i < NST; i++) begin
        if (take[i]) v[i] <= v[i - 1];
        if (ld[i])   tg[i] <= tg[i - 1];
      end
      for (int i = 0; i < LEVELS; i++) begin
        if (ld[i]) begin
          for (int j = 0; j < NUM_IN; j++) begin
            q[i][j] <= nxt[i][j];
          end
        end
      end
    end
  end

`ifdef CSA_FINAL_ADD_EN
  logic [WIDTH-1:0] fsum;

  always_ff @(posedge clock) begin
    if (reset) begin
      fsum <= '0;
    end else if (ld[LEVELS]) begin
      fsum <= q[LEVELS-1][0] + q[LEVELS-1][1];
    end
  end

  assign io.io_out_sum   = fsum;
  assign io.io_out_carry = '0;
`else
  assign io.io_out_sum   = q[LEVELS-1][0];
  assign io.io_out_carry = q[LEVELS-1][1];
`endif

  assign io.io_out_valid = v[NST-1];
  assign io.io_out_tag   = tg[NST-1];
  assign io.io_in_ready  = take[0];

endmodule

// File: tb/tb_csa_reduce_pipe.sv
// tb_csa_reduce_pipe: directed checks of three tree depths (3, 4 and 9 operands).
// Expected rows are hand-derived; streaming beats are scored on sum+carry and tag order.
module tb_csa_reduce_pipe;
  localparam int W  = 10;
  localparam int TW = 4;
`ifdef CSA_FINAL_ADD_EN
  localparam int FA = 1;
`else
  localparam int FA = 0;
`endif
  localparam int L3 = 1 + FA;
  localparam int L4 = 2 + FA;
  localparam int L9 = 4 + FA;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_run = 0;
  int   n_fail = 0;
  int   nb, nout;
  logic acc, hold;
  logic [W-1:0]  tot, op, sd, hs, hc, ev;
  logic [TW-1:0] ht, et;
  logic [W-1:0]  exp_q [$];
  logic [TW-1:0] tag_q [$];

  always #5 clock = ~clock;

  csa_reduce_pipe_if #(.WIDTH(W), .NUM_IN(3), .TAG_W(TW)) b3 ();
  csa_reduce_pipe_if #(.WIDTH(W), .NUM_IN(4), .TAG_W(TW)) b4 ();
  csa_reduce_pipe_if #(.WIDTH(W), .NUM_IN(9), .TAG_W(TW)) b9 ();

  csa_reduce_pipe #(.WIDTH(W), .NUM_IN(3), .TAG_W(TW)) u3 (
    .clock(clock), .reset(reset), .io(b3));
  csa_reduce_pipe #(.WIDTH(W), .NUM_IN(4), .TAG_W(TW)) u4 (
    .clock(clock), .reset(reset), .io(b4));
  csa_reduce_pipe #(.WIDTH(W), .NUM_IN(9), .TAG_W(TW)) u9 (
    .clock(clock), .reset(reset), .io(b9));

  function automatic logic [W-1:0] es(logic [W-1:0] s, logic [W-1:0] c);
    return (FA != 0) ? s + c : s;
  endfunction

  function automatic logic [W-1:0] ec(logic [W-1:0] c);
    return (FA != 0) ? '0 : c;
  endfunction

  task automatic fl(string nm, logic [31:0] o, logic [31:0] e);
    n_fail++;
    $error("FAIL %s: observed %0h expected %0h", nm, o, e);
  endtask

  initial begin
    b3.io_in_valid = 1'b0; b3.io_in_data = '0; b3.io_in_tag = '0; b3.io_out_ready = 1'b1;
    b4.io_in_valid = 1'b0; b4.io_in_data = '0; b4.io_in_tag = '0; b4.io_out_ready = 1'b1;
    b9.io_in_valid = 1'b0; b9.io_in_data = '0; b9.io_in_tag = '0; b9.io_out_ready = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    n_run++; if (b9.io_out_valid !== 1'b0) fl("rst_v9", b9.io_out_valid, 1'b0);
    n_run++; if (b9.io_out_sum !== 10'h000) fl("rst_sum9", b9.io_out_sum, 10'h000);
    n_run++; if (b9.io_out_carry !== 10'h000) fl("rst_carry9", b9.io_out_carry, 10'h000);
    n_run++; if (b9.io_out_tag !== 4'h0) fl("rst_tag9", b9.io_out_tag, 4'h0);
    n_run++; if (b9.io_in_ready !== 1'b1) fl("rst_rdy9", b9.io_in_ready, 1'b1);
    n_run++; if (b3.io_out_valid !== 1'b0) fl("rst_v3", b3.io_out_valid, 1'b0);
    n_run++; if (b3.io_in_ready !== 1'b1) fl("rst_rdy3", b3.io_in_ready, 1'b1);
    n_run++; if (b4.io_out_valid !== 1'b0) fl("rst_v4", b4.io_out_valid, 1'b0);
    n_run++; if (b4.io_in_ready !== 1'b1) fl("rst_rdy4", b4.io_in_ready, 1'b1);

    for (int k = 0; k < 3; k++) b3.io_in_data[k*W +: W] = 10'h3FF;
    b3.io_in_tag = 4'h5;
    b3.io_in_valid = 1'b1;
    for (int e = 1; e <= L3; e++) begin
      @(negedge clock);
      b3.io_in_valid = 1'b0;
      n_run++;
      if (b3.io_out_valid !== (e == L3))
        fl("u3_valid_time", b3.io_out_valid, (e == L3));
    end
    tot = b3.io_out_sum + b3.io_out_carry;
    n_run++; if (b3.io_out_sum !== es(10'h3FF, 10'h3FE)) fl("u3_sum", b3.io_out_sum, es(10'h3FF, 10'h3FE));
    n_run++; if (b3.io_out_carry !== ec(10'h3FE)) fl("u3_carry", b3.io_out_carry, ec(10'h3FE));
    n_run++; if (tot !== 10'h3FD) fl("u3_total", tot, 10'h3FD);
    n_run++; if (b3.io_out_tag !== 4'h5) fl("u3_tag", b3.io_out_tag, 4'h5);
    @(negedge clock);
    n_run++; if (b3.io_out_valid !== 1'b0) fl("u3_drained", b3.io_out_valid, 1'b0);

    for (int k = 0; k < 9; k++) b9.io_in_data[k*W +: W] = W'(k + 1);
    b9.io_in_tag = 4'hA;
    b9.io_in_valid = 1'b1;
    for (int e = 1; e <= L9; e++) begin
      @(negedge clock);
      b9.io_in_valid = 1'b0;
      n_run++;
      if (b9.io_out_valid !== (e == L9))
        fl("u9_valid_time", b9.io_out_valid, (e == L9));
    end
    tot = b9.io_out_sum + b9.io_out_carry;
    n_run++; if (b9.io_out_sum !== es(10'd13, 10'd32)) fl("u9_sum", b9.io_out_sum, es(10'd13, 10'd32));
    n_run++; if (b9.io_out_carry !== ec(10'd32)) fl("u9_carry", b9.io_out_carry, ec(10'd32));
    n_run++; if (tot !== 10'd45) fl("u9_total", tot, 10'd45);
    n_run++; if (b9.io_out_tag !== 4'hA) fl("u9_tag", b9.io_out_tag, 4'hA);
    @(negedge clock);
    n_run++; if (b9.io_out_valid !== 1'b0) fl("u9_drained", b9.io_out_valid, 1'b0);

    for (int k = 0; k < 3; k++) b4.io_in_data[k*W +: W] = 10'h3FF;
    b4.io_in_data[3*W +: W] = 10'h001;
    b4.io_in_tag = 4'h3;
    b4.io_in_valid = 1'b1;
    @(negedge clock);
    n_run++; if (b4.io_in_ready !== 1'b1) fl("u4_rdy_b2b", b4.io_in_ready, 1'b1);
    b4.io_in_data[3*W +: W] = 10'h003;
    b4.io_in_tag = 4'h4;
    @(negedge clock);
    b4.io_in_valid = 1'b0;
    repeat (L4 - 2) @(negedge clock);
    tot = b4.io_out_sum + b4.io_out_carry;
    n_run++; if (b4.io_out_valid !== 1'b1) fl("u4a_valid", b4.io_out_valid, 1'b1);
    n_run++; if (b4.io_out_sum !== es(10'h000, 10'h3FE)) fl("u4a_sum", b4.io_out_sum, es(10'h000, 10'h3FE));
    n_run++; if (b4.io_out_carry !== ec(10'h3FE)) fl("u4a_carry", b4.io_out_carry, ec(10'h3FE));
    n_run++; if (tot !== 10'h3FE) fl("u4a_total", tot, 10'h3FE);
    n_run++; if (b4.io_out_tag !== 4'h3) fl("u4a_tag", b4.io_out_tag, 4'h3);
    @(negedge clock);
    tot = b4.io_out_sum + b4.io_out_carry;
    n_run++; if (b4.io_out_valid !== 1'b1) fl("u4b_valid", b4.io_out_valid, 1'b1);
    n_run++; if (b4.io_out_sum !== es(10'h002, 10'h3FE)) fl("u4b_sum", b4.io_out_sum, es(10'h002, 10'h3FE));
    n_run++; if (b4.io_out_carry !== ec(10'h3FE)) fl("u4b_carry", b4.io_out_carry, ec(10'h3FE));
    n_run++; if (tot !== 10'h000) fl("u4b_total", tot, 10'h000);
    n_run++; if (b4.io_out_tag !== 4'h4) fl("u4b_tag", b4.io_out_tag, 4'h4);
    @(negedge clock);
    n_run++; if (b4.io_out_valid !== 1'b0) fl("u4_drained", b4.io_out_valid, 1'b0);

    nb = 0;
    b9.io_out_ready = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      b9.io_in_valid = (nb < 6);
      sd = '0;
      for (int k = 0; k < 9; k++) begin
        op = W'(nb * 16 + k);
        b9.io_in_data[k*W +: W] = op;
        sd = sd + op;
      end
      b9.io_in_tag = TW'(nb);
      #1;
      acc = b9.io_in_valid && b9.io_in_ready;
      @(negedge clock);
      if (acc) begin
        exp_q.push_back(sd);
        tag_q.push_back(TW'(nb));
        nb++;
      end
    end
    n_run++; if (nb !== L9) fl("bp_accepts", nb, L9);
    n_run++; if (b9.io_in_ready !== 1'b0) fl("bp_in_ready", b9.io_in_ready, 1'b0);
    n_run++; if (b9.io_out_valid !== 1'b1) fl("bp_out_valid", b9.io_out_valid, 1'b1);
    n_run++; if (b9.io_out_tag !== 4'h0) fl("bp_head_tag", b9.io_out_tag, 4'h0);
    b9.io_out_ready = 1'b1;
    #1;
    n_run++; if (b9.io_in_ready !== 1'b1) fl("bp_rdy_on_drain", b9.io_in_ready, 1'b1);
    nout = 0;
    for (int cyc = 0; cyc < 40 && nout < 6; cyc++) begin
      b9.io_in_valid = (nb < 6);
      sd = '0;
      for (int k = 0; k < 9; k++) begin
        op = W'(nb * 16 + k);
        b9.io_in_data[k*W +: W] = op;
        sd = sd + op;
      end
      b9.io_in_tag = TW'(nb);
      #1;
      acc = b9.io_in_valid && b9.io_in_ready;
      if (b9.io_out_valid) begin
        n_run++;
        if (exp_q.size() == 0) fl("bp_extra", 0, 1);
        if (exp_q.size() > 0) begin
          ev = exp_q.pop_front();
          et = tag_q.pop_front();
          tot = b9.io_out_sum + b9.io_out_carry;
          n_run++; if (tot !== ev) fl("bp_total", tot, ev);
          n_run++; if (b9.io_out_tag !== et) fl("bp_tag", b9.io_out_tag, et);
          nout++;
        end
      end
      @(negedge clock);
      if (acc) begin
        exp_q.push_back(sd);
        tag_q.push_back(TW'(nb));
        nb++;
      end
    end
    n_run++; if (nout !== 6) fl("bp_count", nout, 6);

    nb = 0;
    nout = 0;
    hold = 1'b0;
    hs = '0; hc = '0; ht = '0;
    for (int cyc = 0; cyc < 4000 && nout < 300; cyc++) begin
      b9.io_out_ready = ($urandom_range(0, 3) != 0);
      b9.io_in_valid = (nb < 300) && ($urandom_range(0, 3) != 0);
      sd = '0;
      for (int k = 0; k < 9; k++) begin
        op = W'($urandom_range(0, 1023));
        b9.io_in_data[k*W +: W] = op;
        sd = sd + op;
      end
      b9.io_in_tag = TW'(nb);
      #1;
      if (hold) begin
        n_run++; if (b9.io_out_valid !== 1'b1) fl("st_hold_valid", b9.io_out_valid, 1'b1);
        n_run++; if (b9.io_out_sum !== hs) fl("st_hold_sum", b9.io_out_sum, hs);
        n_run++; if (b9.io_out_carry !== hc) fl("st_hold_carry", b9.io_out_carry, hc);
        n_run++; if (b9.io_out_tag !== ht) fl("st_hold_tag", b9.io_out_tag, ht);
      end
      acc = b9.io_in_valid && b9.io_in_ready;
      if (b9.io_out_valid && b9.io_out_ready) begin
        n_run++;
        if (exp_q.size() == 0) fl("st_extra", 0, 1);
        if (exp_q.size() > 0) begin
          ev = exp_q.pop_front();
          et = tag_q.pop_front();
          tot = b9.io_out_sum + b9.io_out_carry;
          n_run++; if (tot !== ev) fl("st_total", tot, ev);
          n_run++; if (b9.io_out_tag !== et) fl("st_tag", b9.io_out_tag, et);
          nout++;
        end
      end
      hold = b9.io_out_valid && !b9.io_out_ready;
      hs = b9.io_out_sum;
      hc = b9.io_out_carry;
      ht = b9.io_out_tag;
      @(negedge clock);
      if (acc) begin
        exp_q.push_back(sd);
        tag_q.push_back(TW'(nb));
        nb++;
      end
    end
    n_run++; if (nout !== 300) fl("st_count", nout, 300);

    b9.io_out_ready = 1'b1;
    for (int bt = 0; bt < 3; bt++) begin
      for (int k = 0; k < 9; k++) b9.io_in_data[k*W +: W] = W'(bt + k);
      b9.io_in_tag = TW'(7 + bt);
      b9.io_in_valid = 1'b1;
      @(negedge clock);
    end
    b9.io_in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_run++; if (b9.io_out_valid !== 1'b0) fl("mr_valid", b9.io_out_valid, 1'b0);
    n_run++; if (b9.io_in_ready !== 1'b1) fl("mr_rdy", b9.io_in_ready, 1'b1);
    for (int cyc = 0; cyc < L9 + 3; cyc++) begin
      @(negedge clock);
      n_run++;
      if (b9.io_out_valid !== 1'b0) fl("mr_no_stale", b9.io_out_valid, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, observed no finish, required finish");
    $fatal(1, "watchdog");
  end

endmodule
